// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
// sram_mem_controller: splits one 32-bit load/store into two timed 16-bit
// asynchronous SRAM cycles while holding the pipeline frozen via ready.
// Revision: 1.0
// ============================================================================
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] w_offset;
  logic        w_phase;
  logic        w_last;
  logic [15:0] w_dq_out;
  logic        w_unused_bits;

  assign w_offset      = address - 32'(ADDR_BASE);
  assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};
  assign w_phase       = (state_q == S_LOW) || (state_q == S_HIGH);
  assign w_last        = (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en || rd_en) begin
          op_wr_d = wr_en;
          word_d  = w_offset[18:2];
          wdata_d = write_data;
          cnt_d   = 4'd0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_HIGH;
          if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // WE_N rises on the last phase cycle so the write closes before the address moves.
  assign w_dq_out  = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = (w_phase && op_wr_q) ? w_dq_out : 16'hzzzz;
  assign SRAM_ADDR = w_phase ? {word_q, (state_q == S_HIGH)} : 18'd0;
  assign SRAM_WE_N = !(w_phase && op_wr_q && !w_last);
  assign SRAM_OE_N = !(w_phase && !op_wr_q);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign read_data = rdata_q;
  assign ready     = ((state_q == S_IDLE) && !wr_en && !rd_en) || (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
// tb_sram_mem_controller: directed and randomized checks against a word-level
// memory model and an asynchronous SRAM device model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sram_mem_controller;
  localparam int W    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [17:0] SRAM_ADDR;
  wire         we_n, oe_n, ce_n, ub_n, lb_n;

  sram_mem_controller #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM device: drives the bus on read, captures while WE_N is low.
  logic        init_mem = 1'b1;
  logic [15:0] sram [0:511];
  assign SRAM_DQ = (!oe_n && we_n) ? sram[SRAM_ADDR[8:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) sram[i] <= 16'h0000;
    end else if (!we_n) begin
      sram[SRAM_ADDR[8:0]] <= SRAM_DQ;
    end
  end

  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rd;
  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic rd, input int widx, input logic [31:0] d,
                     input bit scramble, output int t0, output int t1);
    logic [16:0] w17;
    bit          hi;
    int          pos;
    w17 = widx[16:0];
    t1  = -1;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = BASE + widx * 4; write_data = d;
    #1;
    t0 = cyc;
    chk("ready_request", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      @(negedge clk); #1;
      if (k <= 2 * W) begin
        hi  = (k > W);
        pos = (k - 1) % W;
        chk("ready_busy", {31'd0, ready}, 32'd0);
        chk("sram_addr", {14'd0, SRAM_ADDR}, {14'd0, w17, hi});
        chk("we_n", {31'd0, we_n}, (wr && pos != W - 1) ? 32'd0 : 32'd1);
        chk("oe_n", {31'd0, oe_n}, wr ? 32'd1 : 32'd0);
        if (wr) chk("dq_write", {16'd0, SRAM_DQ}, {16'd0, hi ? d[31:16] : d[15:0]});
        if (k == 1 && scramble) begin
          wr_en = 1'($urandom); rd_en = 1'($urandom);
          address = $urandom; write_data = $urandom;
        end
      end else begin
        t1 = cyc;
        if (wr) ref_mem[widx] = d;
        else    exp_rd = ref_mem[widx];
        chk("ready_done", {31'd0, ready}, 32'd1);
        chk("read_data", read_data, exp_rd);
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    int s0, e0, s1, e1, gap, widx;
    logic wr, rd;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    exp_rd = 32'd0;

    // Reset idle
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("ce_ub_lb", {29'd0, ce_n, ub_n, lb_n}, 32'd0);

    // Write then read-back
    txn(1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0, s0, e0);
    chk("write_latency", e0 - s0, 2 * W + 1);
    txn(1'b0, 1'b1, 1, 32'h0, 1'b0, s0, e0);

    // Both enables: write wins, read_data unchanged
    txn(1'b1, 1'b1, 0, 32'h12345678, 1'b0, s0, e0);
    txn(1'b0, 1'b1, 0, 32'h0, 1'b0, s0, e0);

    // Back-to-back store/load
    txn(1'b1, 1'b0, 2, 32'hA1B2C3D4, 1'b0, s0, e0);
    txn(1'b0, 1'b1, 2, 32'h0, 1'b0, s1, e1);
    chk("b2b_start", s1, e0 + 1);
    chk("b2b_total", e1 - s0 + 1, 12);

    // Reset in the middle of a write
    txn(1'b1, 1'b0, 5, 32'hCAFEF00D, 1'b0, s0, e0);
    @(negedge clk);
    wr_en = 1'b1; address = BASE + 5 * 4; write_data = 32'hA5A55A5A;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    #1;
    chk("midrst_we_n", {31'd0, we_n}, 32'd1);
    chk("midrst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_read_data", read_data, 32'd0);
    ref_mem[5] = {ref_mem[5][31:16], 16'h5A5A};
    exp_rd = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("postrst_ready", {31'd0, ready}, 32'd1);
    chk("postrst_we_n", {31'd0, we_n}, 32'd1);
    txn(1'b0, 1'b1, 5, 32'h0, 1'b0, s0, e0);

    // Randomized traffic with idle gaps and mid-transaction input noise
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); #1;
        chk("gap_ready", {31'd0, ready}, 32'd1);
      end
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      widx = $urandom_range(0, 15);
      d    = $urandom;
      txn(wr, rd, widx, d, 1'($urandom_range(0, 1)), s0, e0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sram_mem_controller.md
# sram_mem_controller

Sequences the ARM pipeline's data-memory accesses onto the external 16-bit asynchronous SRAM. It sits beside the MEM stage and converts one 32-bit load or store into two timed SRAM half-word cycles. It drives `ready` low for the whole transaction, and the top level uses that to freeze every pipeline register. The PC stops advancing and the MEM-stage request stays stable until `ready` returns high.

## Interface
- `WAIT_CYCLES`, default 2: cycles per half-word phase; legal range 2..15.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address, word-aligned.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result.
- `ready`  out  1  high when the MEM stage may advance; low means freeze.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM controls.

## Operation
- **States:** IDLE, LOW, HIGH, DONE. A phase counter `cnt` (4 bits) counts 0..WAIT_CYCLES-1 inside LOW and HIGH.
- **Address map:**
  - `word = (address - ADDR_BASE) >> 2`, truncated to 17 bits.
  - LOW phase: `SRAM_ADDR = {word, 1'b0}`, carrying bits [15:0].
  - HIGH phase: `SRAM_ADDR = {word, 1'b1}`, carrying bits [31:16].
- **IDLE:**
  - If `wr_en` or `rd_en` is high: latch op (write if `wr_en`, which wins when both are high), address and write_data; go to LOW with `cnt=0`.
  - Inputs are not sampled in any other state; changes mid-transaction are ignored.
- **LOW / HIGH:**
  - `cnt` increments each cycle.
  - When `cnt==WAIT_CYCLES-1`: clear `cnt` and advance LOW->HIGH or HIGH->DONE.
- **DONE:** lasts one cycle, then unconditionally returns to IDLE. In the next cycle, IDLE may accept a new request, which is the next instruction's request after the pipeline advanced.
- **Write:**
  - `SRAM_DQ` is driven with the latched half-word throughout LOW/HIGH.
  - `SRAM_WE_N=0` for every phase cycle except the last (`cnt==WAIT_CYCLES-1`), so WE rises before the address changes.
  - `SRAM_OE_N=1`.
- **Read:**
  - `SRAM_DQ` is high-Z and `SRAM_OE_N=0` during LOW/HIGH; `SRAM_WE_N=1`.
  - At the clock edge ending the last LOW cycle, sample DQ into `read_data[15:0]`.
  - At the edge ending the last HIGH cycle, sample DQ into `read_data[31:16]`.
  - `read_data` holds until overwritten by a later read. Writes never modify it.
- **Outside LOW/HIGH:** DQ is high-Z, `SRAM_WE_N=1`, `SRAM_OE_N=1`.
- `SRAM_CE_N`, `SRAM_UB_N` and `SRAM_LB_N` are constant 0.
- **`ready` (combinational):** `(state==IDLE && !wr_en && !rd_en) || state==DONE`.

## Timing
- **Reset values:** state IDLE, `cnt=0`, `read_data=0`, DQ high-Z, WE_N/OE_N=1, `SRAM_ADDR=0`. `ready` is therefore 1 while no request is present.
- **Reset mid-transaction:** abort immediately with the outputs above. No partial half-word is written after reset deasserts.
- **Latency:**
  - A request seen in IDLE at cycle 0 holds `ready` low for cycles 0..2·WAIT_CYCLES.
  - `ready` is high in cycle 2·WAIT_CYCLES+1 (DONE), and `read_data` is valid in that cycle.
  - Default: freeze for 5 cycles, complete in the 6th.
- **Back-to-back:** a request present in the cycle after DONE starts immediately; `ready` is low again that cycle.
- **Request deasserted mid-transaction:** the transaction still completes.

## Test plan
1. **Reset idle:** hold `rst=0`, then release with no request -> `ready=1`, `read_data=0`, DQ=Z, `SRAM_WE_N=SRAM_OE_N=1`.
2. **Write:** write `0xDEADBEEF` to address 1028 (W=2) -> `SRAM_ADDR` is 2 with DQ=`0xBEEF`, then 3 with DQ=`0xDEAD`. WE_N is low for exactly 1 cycle per phase. `ready` is low for 5 cycles and high in the 6th.
3. **Read-back:** read address 1028 from an SRAM model holding the item-2 data -> `read_data=0xDEADBEEF` in the DONE cycle; OE_N is low for 4 cycles.
4. **Both enables high:** assert `wr_en` and `rd_en` with `write_data=0x12345678` to address 1024 -> a write is performed to half-words 0/1 and `read_data` is unchanged.
5. **Back-to-back:** store to 1032 immediately followed by a load from 1032 -> the second transaction starts the cycle after DONE and returns the stored value. Total 12 cycles.
6. **Reset mid-write:** assert `rst=0` at LOW `cnt=1`, then release -> state IDLE, WE_N=1, DQ=Z; the SRAM high half at that address is untouched.
